// File: rtl/char_normalizer.sv
// Character normalizer: folds runs of whitespace into a single space, drops illegal bytes, and buffers kept bytes in a small FIFO.
// Optional lowercase folding of 'A'..'Z' is enabled by defining CHAR_NORMALIZER_CASEFOLD_EN.
module char_normalizer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

   logic [7:0]       mem_q [DEPTH];
   logic [7:0]       mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      occ_q, occ_d;
   logic             prev_sep_q, prev_sep_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic       accept_s;
   logic       pop_s;
   logic       is_sep_s;
   logic       is_print_s;
   logic       push_s;
   logic       drop_s;
   logic [7:0] wdata_s;

   assign in_ready  = (occ_q < FULL_C);
   assign out_valid = (occ_q != (AW+1)'(0));
   assign out_data  = mem_q[rd_ptr_q];
   assign drop_cnt  = drop_cnt_q;

   always_comb begin
      accept_s   = in_valid && in_ready;
      pop_s      = out_valid && out_ready;
      is_sep_s   = (in_data == 8'h20) || (in_data == 8'h09) ||
                   (in_data == 8'h0A) || (in_data == 8'h0D);
      is_print_s = (in_data >= 8'h21) && (in_data <= 8'h7E);
      push_s     = accept_s && ((is_sep_s && !prev_sep_q) || is_print_s);
      drop_s     = accept_s && !push_s;

      wdata_s = in_data;
      if (is_sep_s) begin
         wdata_s = 8'h20;
      end else begin
`ifdef CHAR_NORMALIZER_CASEFOLD_EN
         if ((in_data >= 8'h41) && (in_data <= 8'h5A)) begin
            wdata_s = in_data + 8'h20;
         end else begin
            wdata_s = in_data;
         end
`else
         wdata_s = in_data;
`endif
      end

      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      prev_sep_d = prev_sep_q;
      drop_cnt_d = drop_cnt_q;

      if (push_s) begin
         mem_d[wr_ptr_q] = wdata_s;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   occ_d = occ_q + (AW+1)'(1);
         2'b01:   occ_d = occ_q - (AW+1)'(1);
         default: occ_d = occ_q;
      endcase

      // Illegal bytes leave prev_sep alone so "a",0x01," " still emits the space.
      if (accept_s && is_sep_s) begin
         prev_sep_d = 1'b1;
      end else if (accept_s && is_print_s) begin
         prev_sep_d = 1'b0;
      end else begin
         prev_sep_d = prev_sep_q;
      end

      if (drop_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         prev_sep_q <= 1'b1;
         drop_cnt_q <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         prev_sep_q <= prev_sep_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

endmodule

// File: tb/tb_char_normalizer.sv
// Directed self-checking bench for char_normalizer; a second instance with CNT_W=2 covers counter saturation.
module tb_char_normalizer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready = 1'b1;
   logic [15:0] drop_cnt;

   logic        in2_valid = 1'b0;
   logic [7:0]  in2_data = 8'h00;
   logic        in2_ready;
   logic        out2_valid;
   logic [7:0]  out2_data;
   logic [1:0]  drop2_cnt;

   int checks = 0;
   int failures = 0;
   logic [7:0] got[$];

   char_normalizer #(.DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .drop_cnt(drop_cnt)
   );

   char_normalizer #(.DEPTH(4), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in2_valid), .in_data(in2_data),
      .in_ready(in2_ready), .out_valid(out2_valid), .out_data(out2_data),
      .out_ready(1'b1), .drop_cnt(drop2_cnt)
   );

   always #5 clk = ~clk;

   // Record every transfer that the next rising edge will complete.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) got.push_back(out_data);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input string exp);
      logic [7:0] obs;
      chk({tag, "_len"}, got.size(), exp.len());
      for (int i = 0; i < exp.len(); i++) begin
         obs = (i < got.size()) ? got[i] : 8'hxx;
         chk($sformatf("%s_%0d", tag, i), {24'd0, obs}, {24'd0, exp[i]});
      end
      got.delete();
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      got.delete();
      idle(1);
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'h00);
      chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      idle(2);
      reset = 1'b0;
      idle(1);

      // Whitespace collapsing
      out_ready = 1'b1;
      send_str("  begin\t\tend\n");
      idle(4);
      chk_out("ws", "begin end ");
      chk("ws_drop", {16'd0, drop_cnt}, 32'd3);

      // Optional case folding
      do_reset();
      send_str("BeGiN");
      idle(4);
`ifdef CHAR_NORMALIZER_CASEFOLD_EN
      chk_out("fold", "begin");
`else
      chk_out("fold", "BeGiN");
`endif

      // Backpressure and full FIFO
      do_reset();
      out_ready = 1'b0;
      send_str("abcd");
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1;
      in_data  = "e";
      idle(2);
      chk("held_in_ready", {31'd0, in_ready}, 32'd0);
      chk("held_out_valid", {31'd0, out_valid}, 32'd1);
      chk("held_out_data", {24'd0, out_data}, 32'h61);
      out_ready = 1'b1;
      send("e");
      idle(8);
      chk_out("bp", "abcde");
      chk("bp_empty", {31'd0, out_valid}, 32'd0);

      // Illegal bytes
      do_reset();
      send(8'h00); send(8'h7F); send(8'h80); send("x");
      idle(3);
      chk_out("ill", "x");
      chk("ill_drop", {16'd0, drop_cnt}, 32'd3);
      send("a"); send(8'h01); send(" "); send("b");
      idle(3);
      chk_out("ill_sep", "a b");
      chk("ill_drop2", {16'd0, drop_cnt}, 32'd4);

      // Asynchronous reset mid-stream with 3 entries held
      do_reset();
      out_ready = 1'b0;
      send(8'h01);
      send("p"); send("q"); send("r");
      chk("pre_rst_drop", {16'd0, drop_cnt}, 32'd1);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_out_data", {24'd0, out_data}, 32'h00);
      @(posedge clk); #1;
      reset = 1'b0;
      got.delete();
      out_ready = 1'b1;
      send_str(" x");
      idle(3);
      chk_out("arst_stream", "x");

      // Drop counter saturation on the narrow instance
      do_reset();
      in2_valid = 1'b1;
      in2_data  = 8'h00;
      idle(2);
      chk("sat_two", {30'd0, drop2_cnt}, 32'd2);
      idle(3);
      in2_valid = 1'b0;
      chk("sat_three", {30'd0, drop2_cnt}, 32'd3);
      idle(2);
      chk("sat_hold", {30'd0, drop2_cnt}, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
